// File: rtl/robbie_wheel_drive.sv
// Glyph-to-wheel decoder: glitch filter, illegal-glyph fault, PWM motor enables; cmd follows a held glyph after STABLE_CYCLES, no backpressure.
// ROBBIE_SOFTSTART_EN ramps duty by RAMP_STEP per PWM period; undefined, duty jumps to full scale on the next edge.
module robbie_wheel_drive #(
  parameter int         STABLE_CYCLES = 4,
  parameter int         PWM_BITS      = 8,
  parameter int         RAMP_STEP     = 16,
  parameter logic [6:0] F_GLYPH       = 7'b0001110,
  parameter logic [6:0] S_GLYPH       = 7'b0010010
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX0,
  output logic       lw_cmd,
  output logic       rw_cmd,
  output logic [1:0] motion,
  output logic       lw_pwm,
  output logic       rw_pwm,
  output logic       fault
);

`ifdef ROBBIE_SOFTSTART_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  localparam int                  SUM_W    = PWM_BITS + 2;
  localparam logic [3:0]          STABLE_N = 4'(STABLE_CYCLES);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);
  // Without soft-start a full-scale step saturates duty in one update.
  localparam int                  STEP     = SOFT_EN ? RAMP_STEP : (1 << PWM_BITS);
  localparam logic [SUM_W-1:0]    STEP_S   = SUM_W'(STEP);

  // Index 1 is the left wheel (HEX1), index 0 the right wheel (HEX0).
  logic [1:0][6:0]          glyph;
  logic [1:0][6:0]          cand;
  logic [1:0][3:0]          cnt;
  logic [1:0][3:0]          cnt_nxt;
  logic [1:0]               vld;
  logic [1:0]               go;
  logic [1:0]               stable;
  logic [1:0]               cmd;
  logic [1:0]               pwm_q;
  logic [1:0][PWM_BITS-1:0] duty;
  logic [1:0][SUM_W-1:0]    sum;
  logic [1:0][PWM_BITS-1:0] duty_inc;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic                     wrap;
  logic                     fault_set;
  logic                     fault_clr;
  logic                     fault_nxt;

  assign glyph = {HEX1, HEX0};
  assign wrap  = (pwm_cnt == DUTY_MAX);

  always_comb begin
    vld      = '0;
    go       = '0;
    stable   = '0;
    cnt_nxt  = '0;
    sum      = '0;
    duty_inc = '0;
    for (int w = 0; w < 2; w++) begin
      go[w]  = (glyph[w] == F_GLYPH);
      vld[w] = go[w] || (glyph[w] == S_GLYPH);
      // Stability counts the current cycle, so a glyph held from cycle t lands on cmd at t+STABLE_CYCLES.
      if (glyph[w] != cand[w]) begin
        cnt_nxt[w] = 4'd1;
      end else if (cnt[w] == STABLE_N) begin
        cnt_nxt[w] = cnt[w];
      end else begin
        cnt_nxt[w] = cnt[w] + 4'd1;
      end
      stable[w]   = (cnt_nxt[w] == STABLE_N);
      sum[w]      = {2'b00, duty[w]} + STEP_S;
      duty_inc[w] = (sum[w] > SUM_W'(DUTY_MAX)) ? DUTY_MAX : sum[w][PWM_BITS-1:0];
    end
  end

  // Set beats clear: a still-invalid wheel keeps the fault asserted.
  assign fault_set = |(stable & ~vld);
  assign fault_clr = &(stable & vld);
  assign fault_nxt = fault_set | (fault & ~fault_clr);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cand    <= '0;
      cnt     <= '0;
      cmd     <= '0;
      fault   <= 1'b0;
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_q   <= '0;
    end else begin
      cand    <= glyph;
      cnt     <= cnt_nxt;
      fault   <= fault_nxt;
      pwm_cnt <= pwm_cnt + CNT_ONE;
      for (int w = 0; w < 2; w++) begin
        if (fault_nxt) begin
          cmd[w] <= 1'b0;
        end else if (stable[w] && vld[w]) begin
          cmd[w] <= go[w];
        end
        // Stopping is never ramped; a falling cmd beats a coincident wrap.
        if (!cmd[w] || fault) begin
          duty[w] <= '0;
        end else if (wrap || !SOFT_EN) begin
          duty[w] <= duty_inc[w];
        end
        pwm_q[w] <= (pwm_cnt < duty[w]);
      end
    end
  end

  assign lw_cmd = cmd[1];
  assign rw_cmd = cmd[0];
  assign motion = cmd;
  assign lw_pwm = pwm_q[1];
  assign rw_pwm = pwm_q[0];

endmodule
